// File: rtl/bulls_cows_game_if.sv
// Entry/display bus of the Bulls & Cows controller: the front panel is the
// master (digit switches, confirm button), the game controller is the slave.
interface bulls_cows_game_if #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_TURNS = 10
);
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int TURN_W = $clog2(MAX_TURNS + 1);

  logic [DIGITS*DIGIT_W-1:0] guess;
  logic                      confirm;
  logic [2:0]                state;
  logic                      player;
  logic [CNT_W-1:0]          bulls;
  logic [CNT_W-1:0]          cows;
  logic [1:0]                winner;
  logic [TURN_W-1:0]         turn;
  logic                      err;

  modport master (
    output guess, confirm,
    input  state, player, bulls, cows, winner, turn, err
  );

  modport slave (
    input  guess, confirm,
    output state, player, bulls, cows, winner, turn, err
  );
endinterface

// File: rtl/bulls_cows_game.sv
// Two-player Bulls & Cows controller: validates entries, scores each guess
// against the opponent's secret in one cycle, and tracks rounds, wins and draws.
module bulls_cows_game #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter int RADIX     = 10,
  parameter int MAX_TURNS = 10
) (
  input logic              clock,
  input logic              reset,
  bulls_cows_game_if.slave bus
);
  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int TURN_W = $clog2(MAX_TURNS + 1);

  typedef enum logic [2:0] {
    SECRET_J1 = 3'd0,
    SECRET_J2 = 3'd1,
    GUESS_J1  = 3'd2,
    GUESS_J2  = 3'd3,
    RESULT_J1 = 3'd4,
    RESULT_J2 = 3'd5,
    WIN       = 3'd6,
    DRAW      = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic                player_q, player_d;
  logic [CNT_W-1:0]    bulls_q, bulls_d;
  logic [CNT_W-1:0]    cows_q, cows_d;
  logic [1:0]          winner_q, winner_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic                err_q, err_d;
  logic [CODE_W-1:0]   secret1_q, secret1_d;
  logic [CODE_W-1:0]   secret2_q, secret2_d;
  logic                confirm_q;
  logic                cpulse;

  logic [DIGIT_W-1:0]  guess_dig [DIGITS];
  logic [DIGIT_W-1:0]  opp_dig   [DIGITS];
  logic [CODE_W-1:0]   opp_secret;
  logic                entry_valid;
  logic [CNT_W-1:0]    bulls_cnt, cows_cnt;

  // confirm_q resets high so a button held through reset yields no pulse.
  assign cpulse     = bus.confirm & ~confirm_q;
  assign opp_secret = (state_q == GUESS_J2) ? secret1_q : secret2_q;

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      guess_dig[i] = bus.guess[i*DIGIT_W +: DIGIT_W];
      opp_dig[i]   = opp_secret[i*DIGIT_W +: DIGIT_W];
    end
  end

  // NOTE: every always_comb output gets a default before any branch or loop,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    entry_valid = 1'b1;
    bulls_cnt   = '0;
    cows_cnt    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (32'(guess_dig[i]) >= RADIX) entry_valid = 1'b0;
      for (int j = 0; j < DIGITS; j++) begin
        if (j > i && guess_dig[i] == guess_dig[j]) entry_valid = 1'b0;
        if (guess_dig[i] == opp_dig[j]) begin
          if (i == j) bulls_cnt = bulls_cnt + CNT_W'(1);
          else        cows_cnt  = cows_cnt + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order. Secrets are reset as well:
  // an aborted game must not leak a code into the next one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= SECRET_J1;
      player_q  <= 1'b0;
      bulls_q   <= '0;
      cows_q    <= '0;
      winner_q  <= 2'd0;
      turn_q    <= '0;
      err_q     <= 1'b0;
      secret1_q <= '0;
      secret2_q <= '0;
      confirm_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      bulls_q   <= bulls_d;
      cows_q    <= cows_d;
      winner_q  <= winner_d;
      turn_q    <= turn_d;
      err_q     <= err_d;
      secret1_q <= secret1_d;
      secret2_q <= secret2_d;
      confirm_q <= bus.confirm;
    end
  end

  always_comb begin
    state_d   = state_q;
    bulls_d   = bulls_q;
    cows_d    = cows_q;
    winner_d  = winner_q;
    turn_d    = turn_q;
    err_d     = 1'b0;
    secret1_d = secret1_q;
    secret2_d = secret2_q;

    case (state_q)
      SECRET_J1, SECRET_J2: begin
        if (cpulse) begin
          if (!entry_valid) begin
            err_d = 1'b1;
          end else if (state_q == SECRET_J1) begin
            secret1_d = bus.guess;
            state_d   = SECRET_J2;
          end else begin
            secret2_d = bus.guess;
            state_d   = GUESS_J1;
          end
        end
      end
      GUESS_J1, GUESS_J2: begin
        if (cpulse) begin
          if (!entry_valid) begin
            err_d = 1'b1;
          end else begin
            bulls_d = bulls_cnt;
            cows_d  = cows_cnt;
            if (32'(bulls_cnt) == DIGITS) begin
              state_d  = WIN;
              winner_d = (state_q == GUESS_J1) ? 2'd1 : 2'd2;
            end else begin
              state_d = (state_q == GUESS_J1) ? RESULT_J1 : RESULT_J2;
            end
          end
        end
      end
      RESULT_J1: if (cpulse) state_d = GUESS_J2;
      RESULT_J2: begin
        if (cpulse) begin
          turn_d = turn_q + TURN_W'(1);
          if (32'(turn_d) == MAX_TURNS) begin
            state_d  = DRAW;
            winner_d = 2'd3;
          end else begin
            state_d = GUESS_J1;
          end
        end
      end
      WIN, DRAW: begin
        if (cpulse) begin
          state_d   = SECRET_J1;
          secret1_d = '0;
          secret2_d = '0;
          bulls_d   = '0;
          cows_d    = '0;
          winner_d  = 2'd0;
          turn_d    = '0;
        end
      end
      default: state_d = SECRET_J1;
    endcase

    // The active player follows the next state; WIN/DRAW keep the last one.
    case (state_d)
      SECRET_J1, GUESS_J1, RESULT_J1: player_d = 1'b0;
      SECRET_J2, GUESS_J2, RESULT_J2: player_d = 1'b1;
      default:                        player_d = player_q;
    endcase
  end

  always_comb begin
    bus.state  = state_q;
    bus.player = player_q;
    bus.bulls  = bulls_q;
    bus.cows   = cows_q;
    bus.winner = winner_q;
    bus.turn   = turn_q;
    bus.err    = err_q;
  end
endmodule

// File: doc/bulls_cows_game.md
# bulls_cows_game

Parametrised two-player Bulls & Cows game controller. It sits between the board's digit-entry switches/confirm button and the seven-segment/LED display logic. Supports configurable code length, digit width, radix and per-player turn limit, and adds entry validation, synchronous confirm edge detection, registered scoring, draw detection and an explicit winner output.

## Interface

**Parameters**
- `DIGITS`, 4: code length in digits, 2..8.
- `DIGIT_W`, 4: bits per digit.
- `RADIX`, 10: legal digit values are 0..RADIX-1, with RADIX ≤ 2^DIGIT_W.
- `MAX_TURNS`, 10: guesses allowed per player before a draw, ≥1.

**Ports**
- `clock`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `guess`, in, DIGITS*DIGIT_W: entry value; digit i = `guess[i*DIGIT_W +: DIGIT_W]`.
- `confirm`, in, 1: level from a debounced, synchronised button; acted on at its rising edge.
- `state`, out, 3: current FSM state (encoding below).
- `player`, out, 1: active player (0 = J1, 1 = J2).
- `bulls`, out, $clog2(DIGITS+1): bulls of the last scored guess.
- `cows`, out, $clog2(DIGITS+1): cows of the last scored guess.
- `winner`, out, 2: 0 = none, 1 = J1, 2 = J2, 3 = draw.
- `turn`, out, $clog2(MAX_TURNS+1): completed full rounds (J1 guess followed by J2 guess).
- `err`, out, 1: one-cycle pulse on a rejected entry.

## Operation

- **Confirm detection.** `confirm_q` is a register that resets to 1. `cpulse = confirm & ~confirm_q`. A level held high produces exactly one pulse. If `confirm` is high when reset is released, no pulse occurs until it is released and pressed again.
- **States.** SECRET_J1=0, SECRET_J2=1, GUESS_J1=2, GUESS_J2=3, RESULT_J1=4, RESULT_J2=5, WIN=6, DRAW=7.
- **Validity.** An entry is valid iff every digit is < RADIX and all DIGITS digits are pairwise distinct. The same rule applies to secrets and guesses.
- **SECRET_J1 / SECRET_J2.**
  - `cpulse` with a valid entry stores it as that player's secret and advances to SECRET_J2 or GUESS_J1 respectively.
  - `cpulse` with an invalid entry pulses `err` and leaves the state unchanged.
- **GUESS_Jx.** The guess is compared against the opponent's secret.
  - Valid guess:
    - bulls = count of i where guess[i] == secret[i].
    - cows = count of i≠j pairs where guess[i] == secret[j].
    - Both are registered.
    - If bulls == DIGITS, go to WIN with winner = x.
    - Otherwise go to RESULT_Jx.
  - Invalid guess: `err` pulses, no score update, state unchanged.
- **RESULT_J1.** `cpulse` moves to GUESS_J2.
- **RESULT_J2.** On `cpulse`:
  - `turn` increments.
  - If the new `turn` == MAX_TURNS, go to DRAW with winner = 3.
  - Otherwise go to GUESS_J1.
- **Round completion.** A J1 win ends the game immediately; J2 does not get an equalising guess.
- **WIN / DRAW.** `cpulse` returns to SECRET_J1 and clears secrets, `bulls`, `cows`, `winner` and `turn`. `err` never fires in these states.
- **player.** 0 in SECRET_J1, GUESS_J1, RESULT_J1. 1 in SECRET_J2, GUESS_J2, RESULT_J2. Holds its last value in WIN and DRAW.
- **Unused encodings.** Any unused state value recovers to SECRET_J1 on the next clock.

## Timing

- **Reset values** (asynchronous, immediate): `state` = SECRET_J1, `player` = 0, `bulls` = 0, `cows` = 0, `winner` = 0, `turn` = 0, `err` = 0, secrets = 0, `confirm_q` = 1.
- **Edge detection.** The rising edge of `confirm` is sampled at clock edge N. `cpulse` is high during cycle N to N+1.
- **Update point.** `state`, `bulls`, `cows`, `winner`, `turn` and `err` all update at edge N+1. Latency from the confirm edge to the visible result is one clock.
- **Sampling.** `guess` is sampled combinationally in the `cpulse` cycle and must be stable during that cycle. No other capture register is used.
- **Scoring datapath.** The bulls/cows comparison is purely combinational from `guess` and the secret, then registered. There is no multi-cycle counting.
- **err.** High for exactly the one cycle after a rejected `cpulse`. It is low at all other times.
- **Output stability.** `bulls` and `cows` hold their values through RESULT, WIN and the following GUESS state until the next valid guess.
- **Mid-game reset.** Asserting `reset` in any state aborts the game immediately and all outputs take their reset values. The first `cpulse` after release is treated as a J1 secret.
- **Width overflow.** `turn` never exceeds MAX_TURNS.

## Test plan

1. **Basic scoring.** Defaults; reset; secrets J1 = 0x1234, J2 = 0x5678; J1 guesses 0x5687.
   - Expect `bulls` = 2, `cows` = 2, `state` = 4 one clock after `cpulse`.
   - Then `cpulse` → state 3.
2. **Validation.** In SECRET_J1, confirm 0x1123 and then 0x12A4.
   - Expect one `err` pulse each and `state` remaining 0.
   - Then 0x9876 is accepted and `state` = 1.
3. **J2 win.** Proceed from scenario 1; J2 guesses 0x1234.
   - Expect `bulls` = 4, `cows` = 0, `state` = 6, `winner` = 2.
   - Then `cpulse` → `state` = 0, `turn` = 0, `winner` = 0.
4. **Draw.** MAX_TURNS = 2; secrets 0x0123 and 0x4567; all guesses 0x89AB with RADIX = 16.
   - Expect `bulls` = `cows` = 0 after every guess.
   - After the 2nd RESULT_J2 confirm, `turn` = 2, `state` = 7, `winner` = 3.
5. **Held confirm.** Hold `confirm` high for 10 cycles in SECRET_J1 with a valid entry.
   - Expect exactly one transition.
   - Repeat with `confirm` already high at reset release: no transition until it is released and re-pressed.
6. **Reset mid-game.** Assert `reset` in GUESS_J2 at `turn` = 3.
   - Expect all outputs at their reset values in the same cycle.
   - After release, a new secret entry is accepted normally.
